instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 224 ++++++++++++++++++++++
 tb/tb_instr_fetch.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: fetches a two-byte instruction from byte-wide program memory
// for the CPU, with per-byte wait timeout and misaligned-address fault.
// Optional prefetch of the next instruction is compiled in by defining
// INSTR_FETCH_PREFETCH_EN; without it every request reads memory.
module instr_fetch #(
  parameter logic [7:0] FILL_OPCODE  = 8'h00,
  parameter int         MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [7:0] rom_address,
  input  logic       fetch_req,
  output logic [7:0] opcode1,
  output logic [7:0] opcode2,
  output logic       fetch_ack,
  output logic       fault,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  input  logic [7:0] mem_data,
  input  logic       mem_ready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD1  = 3'd1;
  localparam logic [2:0] S_RD2  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
`ifdef INSTR_FETCH_PREFETCH_EN
  localparam logic [2:0] S_PF1  = 3'd4;
  localparam logic [2:0] S_PF2  = 3'd5;
`endif

  // The counter only has to reach MEM_WAIT_MAX-1; the next low cycle times out.
  localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  logic [2:0]        r_state;
  logic [7:0]        r_addrQ;
  logic [7:0]        r_byte0;
  logic [WAIT_W-1:0] r_waitCnt;
  logic [7:0]        r_opcode1;
  logic [7:0]        r_opcode2;
  logic              r_fetchAck;
  logic              r_fault;
  logic [7:0]        r_memAddr;
  logic              r_memRd;
  logic              w_waitExpired;
`ifdef INSTR_FETCH_PREFETCH_EN
  logic              r_pfArmed;
  logic              r_pfValid;
  logic [7:0]        r_pfTag;
  logic [7:0]        r_pfByte0;
  logic [7:0]        r_pfByte1;
`endif

  assign opcode1       = r_opcode1;
  assign opcode2       = r_opcode2;
  assign fetch_ack     = r_fetchAck;
  assign fault         = r_fault;
  assign mem_addr      = r_memAddr;
  assign mem_rd        = r_memRd;
  assign w_waitExpired = (r_waitCnt == WAIT_LAST);

  // Fetch sequencer: all outputs are registered and change on the edge
  // that moves the FSM, so mem_rd/mem_addr track the read states exactly.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state    <= S_IDLE;
      r_addrQ    <= 8'h00;
      r_byte0    <= 8'h00;
      r_waitCnt  <= '0;
      r_opcode1  <= FILL_OPCODE;
      r_opcode2  <= FILL_OPCODE;
      r_fetchAck <= 1'b0;
      r_fault    <= 1'b0;
      r_memAddr  <= 8'h00;
      r_memRd    <= 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
      r_pfArmed  <= 1'b0;
      r_pfValid  <= 1'b0;
      r_pfTag    <= 8'h00;
      r_pfByte0  <= 8'h00;
      r_pfByte1  <= 8'h00;
`endif
    end else begin
      r_fetchAck <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_memRd <= 1'b0;
          if (fetch_req) begin
`ifdef INSTR_FETCH_PREFETCH_EN
            r_pfArmed <= 1'b0;
`endif
            if (rom_address[0]) begin
              // Misaligned: fault immediately, never touch memory.
              r_state    <= S_DONE;
              r_fetchAck <= 1'b1;
              r_fault    <= 1'b1;
              r_opcode1  <= FILL_OPCODE;
              r_opcode2  <= FILL_OPCODE;
`ifdef INSTR_FETCH_PREFETCH_EN
              r_pfValid  <= 1'b0;
`endif
            end
`ifdef INSTR_FETCH_PREFETCH_EN
            else if (r_pfValid && (rom_address == r_pfTag)) begin
              // Prefetch hit: answer from the buffer without a memory read.
              r_addrQ    <= rom_address;
              r_state    <= S_DONE;
              r_fetchAck <= 1'b1;
              r_fault    <= 1'b0;
              r_opcode1  <= r_pfByte0;
              r_opcode2  <= r_pfByte1;
              r_pfArmed  <= (rom_address != 8'hFE);
            end
`endif
            else begin
              r_addrQ   <= rom_address;
              r_state   <= S_RD1;
              r_memRd   <= 1'b1;
              r_memAddr <= rom_address;
              r_waitCnt <= '0;
`ifdef INSTR_FETCH_PREFETCH_EN
              r_pfValid <= 1'b0;
`endif
            end
          end
`ifdef INSTR_FETCH_PREFETCH_EN
          else if (r_pfArmed) begin
            // Quiet cycle after a good fetch: read the next instruction ahead.
            r_pfArmed <= 1'b0;
            r_pfValid <= 1'b0;
            r_state   <= S_PF1;
            r_memRd   <= 1'b1;
            r_memAddr <= r_addrQ + 8'd2;
            r_waitCnt <= '0;
          end
`endif
        end

        S_RD1: begin
          if (mem_ready) begin
            r_byte0   <= mem_data;
            r_state   <= S_RD2;
            r_memAddr <= r_addrQ + 8'd1;
            r_waitCnt <= '0;
          end else if (w_waitExpired) begin
            r_state    <= S_DONE;
            r_memRd    <= 1'b0;
            r_fetchAck <= 1'b1;
            r_fault    <= 1'b1;
            r_opcode1  <= FILL_OPCODE;
            r_opcode2  <= FILL_OPCODE;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end

        S_RD2: begin
          if (mem_ready) begin
            r_state    <= S_DONE;
            r_memRd    <= 1'b0;
            r_fetchAck <= 1'b1;
            r_fault    <= 1'b0;
            r_opcode1  <= r_byte0;
            r_opcode2  <= mem_data;
`ifdef INSTR_FETCH_PREFETCH_EN
            r_pfArmed  <= (r_addrQ != 8'hFE);
`endif
          end else if (w_waitExpired) begin
            r_state    <= S_DONE;
            r_memRd    <= 1'b0;
            r_fetchAck <= 1'b1;
            r_fault    <= 1'b1;
            r_opcode1  <= FILL_OPCODE;
            r_opcode2  <= FILL_OPCODE;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

`ifdef INSTR_FETCH_PREFETCH_EN
        S_PF1: begin
          if (mem_ready) begin
            r_pfByte0 <= mem_data;
            r_state   <= S_PF2;
            r_memAddr <= r_addrQ + 8'd3;
            r_waitCnt <= '0;
          end else if (w_waitExpired) begin
            r_state <= S_IDLE;
            r_memRd <= 1'b0;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end

        S_PF2: begin
          if (mem_ready) begin
            r_pfByte1 <= mem_data;
            r_pfTag   <= r_addrQ + 8'd2;
            r_pfValid <= 1'b1;
            r_state   <= S_IDLE;
            r_memRd   <= 1'b0;
          end else if (w_waitExpired) begin
            r_state <= S_IDLE;
            r_memRd <= 1'b0;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end
`endif

        default: begin
          r_state <= S_IDLE;
          r_memRd <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table-driven directed test of instr_fetch against a
// byte memory whose ready response is delayed a programmable number of cycles.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic [7:0] rom_address = 8'h00;
  logic       fetch_req = 1'b0;
  logic [7:0] opcode1;
  logic [7:0] opcode2;
  logic       fetch_ack;
  logic       fault;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_data;
  logic       mem_ready;

  int totalCount = 0;
  int badCount = 0;

  logic [7:0] mem [256];
  int readyDelay = 0;
  int lowCnt = 0;

  typedef struct {
    logic [7:0] addr;
    int         delay;
    int         lat;
    logic [7:0] op1;
    logic [7:0] op2;
    logic       flt;
  } vec_t;

  vec_t vecs[9];

`ifdef INSTR_FETCH_PREFETCH_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 3;
`endif

  instr_fetch #(.FILL_OPCODE(8'h00), .MEM_WAIT_MAX(15)) dut (
    .clk(clk),
    .n_reset(n_reset),
    .rom_address(rom_address),
    .fetch_req(fetch_req),
    .opcode1(opcode1),
    .opcode2(opcode2),
    .fetch_ack(fetch_ack),
    .fault(fault),
    .mem_addr(mem_addr),
    .mem_rd(mem_rd),
    .mem_data(mem_data),
    .mem_ready(mem_ready)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Memory model: data is combinational, ready comes after readyDelay low cycles per byte.
  assign mem_data  = mem[mem_addr];
  assign mem_ready = mem_rd && (lowCnt >= readyDelay);

  // Count low-ready cycles of the current byte; restart on each handshake.
  always @(posedge clk) begin
    if (!mem_rd || mem_ready) lowCnt <= 0;
    else lowCnt <= lowCnt + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCount++;
    if (actual !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] addr, input int delay);
    readyDelay  = delay;
    rom_address = addr;
    fetch_req   = 1'b1;
  endtask

  // Called at a negedge in an idle cycle; returns at the negedge after the ack.
  task automatic runFetch(input string name, input logic [7:0] addr, input int delay,
                          input int expLat, input logic [7:0] e1, input logic [7:0] e2,
                          input logic eF);
    int  lat;
    bit  got;
    bit  rdSeen;
    lat    = 0;
    got    = 0;
    rdSeen = 0;
    applyStimulus(addr, delay);
    @(posedge clk);
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        fetch_req   = 1'b0;
        rom_address = ~addr;
      end
      if (mem_rd) rdSeen = 1;
      if (delay == 0 && expLat >= 3) begin
        if (lat == 1) checkOutput({name, ".addr0"}, {24'h0, mem_addr}, {24'h0, addr});
        if (lat == 2) checkOutput({name, ".addr1"}, {24'h0, mem_addr}, {24'h0, addr | 8'h01});
      end
      if (fetch_ack) got = 1;
    end
    checkOutput({name, ".lat"}, lat, expLat);
    checkOutput({name, ".op1"}, {24'h0, opcode1}, {24'h0, e1});
    checkOutput({name, ".op2"}, {24'h0, opcode2}, {24'h0, e2});
    checkOutput({name, ".fault"}, {31'h0, fault}, {31'h0, eF});
    if (addr[0]) checkOutput({name, ".noread"}, {31'h0, rdSeen}, 32'h0);
    @(negedge clk);
    checkOutput({name, ".pulse"}, {31'h0, fetch_ack}, 32'h0);
  endtask

  // Test sequence: reset, vector table, reset abort, prefetch hit/miss.
  initial begin
    int ackSeen;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
    mem[8'h10] = 8'h12;
    mem[8'h11] = 8'h34;

    vecs[0] = '{8'h10, 0,    3,  8'h12, 8'h34, 1'b0};
    vecs[1] = '{8'h21, 0,    1,  8'h00, 8'h00, 1'b1};
    vecs[2] = '{8'h40, 3,    9,  8'h83, 8'h82, 1'b0};
    vecs[3] = '{8'h40, 1000, 16, 8'h00, 8'h00, 1'b1};
    vecs[4] = '{8'hFE, 0,    3,  8'h3D, 8'h3C, 1'b0};
    vecs[5] = '{8'h00, 1,    5,  8'hC3, 8'hC2, 1'b0};
    vecs[6] = '{8'h80, 14,   31, 8'h43, 8'h42, 1'b0};
    vecs[7] = '{8'h82, 15,   16, 8'h00, 8'h00, 1'b1};
    vecs[8] = '{8'h10, 0,    3,  8'h12, 8'h34, 1'b0};

    repeat (2) @(negedge clk);
    checkOutput("rst.op1", {24'h0, opcode1}, 32'h0);
    checkOutput("rst.op2", {24'h0, opcode2}, 32'h0);
    checkOutput("rst.ack", {31'h0, fetch_ack}, 32'h0);
    checkOutput("rst.fault", {31'h0, fault}, 32'h0);
    checkOutput("rst.rd", {31'h0, mem_rd}, 32'h0);
    checkOutput("rst.addr", {24'h0, mem_addr}, 32'h0);
    n_reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      runFetch($sformatf("v%0d", i), vecs[i].addr, vecs[i].delay, vecs[i].lat,
               vecs[i].op1, vecs[i].op2, vecs[i].flt);
    end

    // Reset pulsed while the second byte is being read.
    applyStimulus(8'h40, 0);
    @(posedge clk);
    @(negedge clk);
    fetch_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort.inRd2", {31'h0, mem_rd}, 32'h1);
    n_reset = 1'b0;
    #1;
    checkOutput("abort.op1", {24'h0, opcode1}, 32'h0);
    checkOutput("abort.op2", {24'h0, opcode2}, 32'h0);
    checkOutput("abort.rd", {31'h0, mem_rd}, 32'h0);
    checkOutput("abort.addr", {24'h0, mem_addr}, 32'h0);
    checkOutput("abort.ack", {31'h0, fetch_ack}, 32'h0);
    @(negedge clk);
    n_reset = 1'b1;
    ackSeen = 0;
    repeat (5) begin
      @(negedge clk);
      if (fetch_ack) ackSeen = 1;
    end
    checkOutput("abort.noack", ackSeen, 0);
    runFetch("post", 8'h00, 0, 3, 8'hC3, 8'hC2, 1'b0);

    // Fetch, idle long enough for any prefetch, then the next sequential address.
    runFetch("pfA", 8'h10, 0, 3, 8'h12, 8'h34, 1'b0);
    repeat (4) @(negedge clk);
    runFetch("pfHit", 8'h12, 0, HIT_LAT, 8'hD1, 8'hD0, 1'b0);
    runFetch("pfMiss", 8'h50, 0, 3, 8'h93, 8'h92, 1'b0);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
